// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings used by both receiver and transmitter,
// default bit timing, and small helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } uart_state_e;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam int DATA_BITS_PER_FRAME = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input, plus a "previous" flop
// for falling-edge detection. All flops reset to 1 so reset never fakes an edge.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detection, mid-bit 3-sample majority vote, and a
// one-cycle valid or framing-error pulse per frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_frame_err,
    output logic       o_rx_active
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID    = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] MID_M1 = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] MID_P1 = CNT_W'((CLKS_PER_BIT - 1) / 2 + 1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_INDEX = 3'(DATA_BITS_PER_FRAME - 1);

    logic w_sync;
    logic w_fall;
    logic w_vote;

    uart_state_e      r_state;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_index;
    logic [7:0]       r_shift;
    logic             r_sample0;
    logic             r_sample1;
    logic [7:0]       r_rx_byte;
    logic             r_rx_dv;
    logic             r_rx_frame_err;
    logic             r_rx_active;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_rx_serial),
        .o_sync  (w_sync),
        .o_fall  (w_fall)
    );

    // The vote resolves at MID+1 from the two stored samples and the live one
    assign w_vote = majority3(r_sample0, r_sample1, w_sync);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample0 <= 1'b1;
            r_sample1 <= 1'b1;
        end else begin
            if (r_count == MID_M1) begin
                r_sample0 <= w_sync;
            end
            if (r_count == MID) begin
                r_sample1 <= w_sync;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_index        <= '0;
            r_shift        <= '0;
            r_rx_byte      <= '0;
            r_rx_dv        <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_rx_active    <= 1'b0;
        end else begin
            r_rx_dv        <= 1'b0;
            r_rx_frame_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    r_index <= '0;
                    if (w_fall) begin
                        r_state     <= START_BIT;
                        r_rx_active <= 1'b1;
                    end
                end

                START_BIT: begin
                    if (r_count == MID_P1 && w_vote) begin
                        r_state     <= IDLE;
                        r_count     <= '0;
                        r_rx_active <= 1'b0;
                    end else if (r_count == LAST) begin
                        r_state <= DATA_BITS;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end

                DATA_BITS: begin
                    if (r_count == MID_P1) begin
                        r_shift[r_index] <= w_vote;
                    end
                    if (r_count == LAST) begin
                        r_count <= '0;
                        if (r_index == LAST_INDEX) begin
                            r_index <= '0;
                            r_state <= STOP_BIT;
                        end else begin
                            r_index <= r_index + 3'd1;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end

                // Decide at mid-stop so a back-to-back start edge is never missed
                STOP_BIT: begin
                    if (r_count == MID_P1) begin
                        if (w_vote) begin
                            r_rx_byte <= r_shift;
                            r_rx_dv   <= 1'b1;
                        end else begin
                            r_rx_frame_err <= 1'b1;
                        end
                        r_state <= CLEANUP;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end

                CLEANUP: begin
                    r_state     <= IDLE;
                    r_count     <= '0;
                    r_rx_active <= 1'b0;
                end

                default: begin
                    r_state     <= IDLE;
                    r_count     <= '0;
                    r_index     <= '0;
                    r_rx_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_dv        = r_rx_dv;
    assign o_rx_byte      = r_rx_byte;
    assign o_rx_frame_err = r_rx_frame_err;
    assign o_rx_active    = r_rx_active;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 16 clocks/bit for most scenarios and one at
// the default 434 clocks/bit for back-to-back frames.
module tb_uart_rx;

    localparam int CPB_FAST = 16;
    localparam int CPB_SLOW = 434;
    localparam int MID_FAST = (CPB_FAST - 1) / 2;

    logic       clk = 1'b0;
    logic       rstN;
    logic       rxFast;
    logic       rxSlow;

    logic       dvFast;
    logic [7:0] byteFast;
    logic       ferrFast;
    logic       activeFast;
    logic       dvSlow;
    logic [7:0] byteSlow;
    logic       ferrSlow;
    logic       activeSlow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int dvCntF        = 0;
    int ferrCntF      = 0;
    int activeRiseF   = 0;
    int lastRiseCyc   = 0;
    int lastDvCyc     = 0;
    int lastFerrCyc   = 0;
    int lastPinFall   = 0;
    int longPulses    = 0;
    int bothHigh      = 0;
    int ferrCntS      = 0;
    logic prevActF    = 1'b0;
    logic prevDvF     = 1'b0;
    logic prevFerrF   = 1'b0;
    logic prevDvS     = 1'b0;
    logic [7:0] slowBytes[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLKS_PER_BIT(CPB_FAST)) u_dutFast (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_rx_serial    (rxFast),
        .o_rx_dv        (dvFast),
        .o_rx_byte      (byteFast),
        .o_rx_frame_err (ferrFast),
        .o_rx_active    (activeFast)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_SLOW)) u_dutSlow (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_rx_serial    (rxSlow),
        .o_rx_dv        (dvSlow),
        .o_rx_byte      (byteSlow),
        .o_rx_frame_err (ferrSlow),
        .o_rx_active    (activeSlow)
    );

    // Event recorder, sampled on the inactive edge
    always @(negedge clk) begin
        if (activeFast && !prevActF) begin
            activeRiseF++;
            lastRiseCyc = cyc;
        end
        if (dvFast) begin
            dvCntF++;
            lastDvCyc = cyc;
        end
        if (ferrFast) begin
            ferrCntF++;
            lastFerrCyc = cyc;
        end
        if ((dvFast && ferrFast) || (dvSlow && ferrSlow)) bothHigh++;
        if ((dvFast && prevDvF) || (ferrFast && prevFerrF) || (dvSlow && prevDvS)) longPulses++;
        if (dvSlow) slowBytes.push_back(byteSlow);
        if (ferrSlow) ferrCntS++;
        prevActF  = activeFast;
        prevDvF   = dvFast;
        prevFerrF = ferrFast;
        prevDvS   = dvSlow;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one line for n cycles; always entered and left on a falling clock edge
    task automatic driveBits(input bit slow, input logic v, input int n);
        if (slow) rxSlow = v;
        else      rxFast = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit slow, input logic [7:0] data, input logic stopVal,
                                 input int noiseBit = -1);
        int cpb = slow ? CPB_SLOW : CPB_FAST;
        lastPinFall = cyc;
        driveBits(slow, 1'b0, cpb);
        for (int i = 0; i < 8; i++) begin
            if (i == noiseBit) begin
                driveBits(slow, data[i], MID_FAST + 1);
                driveBits(slow, ~data[i], 1);
                driveBits(slow, data[i], cpb - MID_FAST - 2);
            end else begin
                driveBits(slow, data[i], cpb);
            end
        end
        driveBits(slow, stopVal, cpb);
    endtask

    initial begin
        int rises;
        int dvBefore;
        int ferrBefore;
        logic [31:0] slow0;
        logic [31:0] slow1;

        rstN   = 1'b1;
        rxFast = 1'b1;
        rxSlow = 1'b1;
        #2 rstN = 1'b0;
        @(negedge clk);

        checkOutput("reset_dv", 32'(dvFast), 32'd0);
        checkOutput("reset_ferr", 32'(ferrFast), 32'd0);
        checkOutput("reset_active", 32'(activeFast), 32'd0);
        checkOutput("reset_byte", 32'(byteFast), 32'h00);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("release_no_pulse", 32'(dvCntF + ferrCntF), 32'd0);

        $display("[TB] single frame 0xA5");
        applyStimulus(1'b0, 8'hA5, 1'b1);
        driveBits(1'b0, 1'b1, 2 * CPB_FAST);
        checkOutput("a5_dv_count", 32'(dvCntF), 32'd1);
        checkOutput("a5_byte", 32'(byteFast), 32'hA5);
        checkOutput("a5_pin_to_start", 32'(lastRiseCyc - lastPinFall), 32'd3);
        checkOutput("a5_start_to_dv", 32'(lastDvCyc - lastRiseCyc), 32'd153);
        checkOutput("a5_no_ferr", 32'(ferrCntF), 32'd0);
        checkOutput("a5_active_low", 32'(activeFast), 32'd0);

        $display("[TB] start glitch");
        rises    = activeRiseF;
        dvBefore = dvCntF;
        driveBits(1'b0, 1'b0, 4);
        driveBits(1'b0, 1'b1, 3 * CPB_FAST);
        checkOutput("glitch_entered_start", 32'(activeRiseF - rises), 32'd1);
        checkOutput("glitch_active_low", 32'(activeFast), 32'd0);
        checkOutput("glitch_no_dv", 32'(dvCntF - dvBefore), 32'd0);
        checkOutput("glitch_no_ferr", 32'(ferrCntF), 32'd0);

        $display("[TB] framing error and break");
        applyStimulus(1'b0, 8'h3C, 1'b1);
        driveBits(1'b0, 1'b1, 2 * CPB_FAST);
        checkOutput("good_3c_byte", 32'(byteFast), 32'h3C);
        dvBefore = dvCntF;
        applyStimulus(1'b0, 8'h55, 1'b0);
        rises = activeRiseF;
        driveBits(1'b0, 1'b0, 20 * CPB_FAST);
        checkOutput("ferr_count", 32'(ferrCntF), 32'd1);
        checkOutput("ferr_start_to_pulse", 32'(lastFerrCyc - lastRiseCyc), 32'd153);
        checkOutput("ferr_byte_kept", 32'(byteFast), 32'h3C);
        checkOutput("ferr_no_dv", 32'(dvCntF - dvBefore), 32'd0);
        checkOutput("break_no_restart", 32'(activeRiseF - rises), 32'd0);
        checkOutput("break_active_low", 32'(activeFast), 32'd0);
        driveBits(1'b0, 1'b1, 2 * CPB_FAST);
        applyStimulus(1'b0, 8'hC3, 1'b1);
        driveBits(1'b0, 1'b1, 2 * CPB_FAST);
        checkOutput("after_break_restart", 32'(activeRiseF - rises), 32'd1);
        checkOutput("after_break_byte", 32'(byteFast), 32'hC3);

        $display("[TB] noise on data bit 3");
        applyStimulus(1'b0, 8'h96, 1'b1, 3);
        driveBits(1'b0, 1'b1, 2 * CPB_FAST);
        checkOutput("noise_byte", 32'(byteFast), 32'h96);

        $display("[TB] reset during data bit 4");
        dvBefore   = dvCntF;
        ferrBefore = ferrCntF;
        driveBits(1'b0, 1'b0, CPB_FAST);
        driveBits(1'b0, 1'b1, 4 * CPB_FAST + 8);
        checkOutput("pre_reset_active", 32'(activeFast), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("reset_now_active", 32'(activeFast), 32'd0);
        checkOutput("reset_now_byte", 32'(byteFast), 32'h00);
        checkOutput("reset_now_pulses", 32'({dvFast, ferrFast}), 32'd0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        driveBits(1'b0, 1'b1, 3 * CPB_FAST);
        checkOutput("reset_no_dv", 32'(dvCntF - dvBefore), 32'd0);
        checkOutput("reset_no_ferr", 32'(ferrCntF - ferrBefore), 32'd0);
        checkOutput("reset_idle_active", 32'(activeFast), 32'd0);
        applyStimulus(1'b0, 8'h5A, 1'b1);
        driveBits(1'b0, 1'b1, 2 * CPB_FAST);
        checkOutput("post_reset_byte", 32'(byteFast), 32'h5A);
        checkOutput("post_reset_dv", 32'(dvCntF - dvBefore), 32'd1);

        $display("[TB] back-to-back frames at 434 clocks per bit");
        applyStimulus(1'b1, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        driveBits(1'b1, 1'b1, 2 * CPB_SLOW);
        slow0 = (slowBytes.size() > 0) ? 32'(slowBytes[0]) : 32'hDEAD;
        slow1 = (slowBytes.size() > 1) ? 32'(slowBytes[1]) : 32'hDEAD;
        checkOutput("b2b_count", 32'(slowBytes.size()), 32'd2);
        checkOutput("b2b_first", slow0, 32'h00);
        checkOutput("b2b_second", slow1, 32'hFF);
        checkOutput("b2b_no_ferr", 32'(ferrCntS), 32'd0);

        checkOutput("pulse_width_one", 32'(longPulses), 32'd0);
        checkOutput("dv_ferr_exclusive", 32'(bothHigh), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
